// File: rtl/sat_term_accumulator.sv
// Frame accumulator for signed add/sub terms with sticky overflow and a valid/ready result port.
// Define SAT_TERM_ACC_SAT_EN to clamp the running sum on overflow instead of wrapping.
module sat_term_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_in_sub,
  input  logic                  i_in_last,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_ovf,
  output logic [CNT_WIDTH-1:0]  o_out_count
);
  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_ovf;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_accept;
  logic                  w_new_frame;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_carry;
  logic                  w_step_ovf;
  logic [DATA_WIDTH-1:0] w_acc_next;
  logic [CNT_WIDTH-1:0]  w_cnt_base;

  assign w_accept    = i_in_valid & o_in_ready;
  // A term taken in IDLE opens a fresh frame, so it starts from zeroed state.
  assign w_new_frame = (r_state == S_IDLE);
  assign w_a         = w_new_frame ? '0 : r_acc;
  assign w_b         = i_in_sub ? ~i_in_data : i_in_data;
  assign w_cnt_base  = w_new_frame ? '0 : r_cnt;

  // Ripple-carry chain of full-adder bit cells; subtract is A + ~B + 1.
  always_comb begin
    w_sum   = '0;
    w_carry = i_in_sub;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_sum[i] = w_a[i] ^ w_b[i] ^ w_carry;
      w_carry  = (w_a[i] & w_b[i]) | (w_carry & (w_a[i] ^ w_b[i]));
    end
  end

  assign w_step_ovf = (w_a[MSB] == w_b[MSB]) & (w_sum[MSB] != w_a[MSB]);

`ifdef SAT_TERM_ACC_SAT_EN
  always_comb begin
    w_acc_next = w_sum;
    if (w_step_ovf)
      w_acc_next = w_a[MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  assign w_acc_next = w_sum;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: if (w_accept) w_next = i_in_last ? S_DONE : S_ACCUM;
      S_DONE:          if (i_out_ready) w_next = S_IDLE;
      default:         w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state != S_DONE);
    o_out_valid = (r_state == S_DONE);
    o_out_data  = o_out_valid ? r_acc : '0;
    o_out_ovf   = o_out_valid & r_ovf;
    o_out_count = o_out_valid ? r_cnt : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      r_ovf <= (r_ovf & ~w_new_frame) | w_step_ovf;
      r_cnt <= w_cnt_base + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else if ((r_state == S_DONE) && i_out_ready) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end
  end

endmodule
